// File: rtl/ucode_pkg.sv
// ucode_pkg
// Shared definitions for the microcode sequencer: microinstruction field
// positions, the built-in fetch microinstructions and the bus source/sink
// select indices used by the microcode assembler and the datapath.
package ucode_pkg;

    // Microinstruction word width.
    localparam int UW = 16;

    // Field positions inside a microinstruction.
    localparam int EO_BIT  = 15;   // ALU output enable, active-low
    localparam int ALU_HI  = 14;   // ALU function bits (overlap the source/rt/pp
    localparam int ALU_LO  = 9;    // fields; meaning depends on EO_BIT)
    localparam int OUT_HI  = 14;   // bus source select field
    localparam int OUT_LO  = 12;
    localparam int RT_BIT  = 11;   // restart step counter
    localparam int PP_BIT  = 10;   // PC increment
    localparam int IN_HI   = 8;    // bus sink select field
    localparam int IN_LO   = 6;
    localparam int JMP_HI  = 5;    // {JC,JZ,JGT,JLT}
    localparam int JMP_LO  = 2;

    // T0: PC drives the bus, MAR latches it.
    localparam logic [UW-1:0] FETCH0_DEF = 16'h8000 | 16'h0040;
    // T1: RAM drives the bus, IR latches it, PC increments.
    localparam logic [UW-1:0] FETCH1_DEF = 16'hB480;

    // Bus source indices (value of the OUT field).
    typedef enum logic [2:0] {
        SRC_PC  = 3'd0,
        SRC_IRH = 3'd1,
        SRC_IRL = 3'd2,
        SRC_RAM = 3'd3,
        SRC_DEV = 3'd6
    } bus_src_e;

    // Bus sink indices (value of the IN field); 0 means "no sink".
    typedef enum logic [2:0] {
        DST_NONE = 3'd0,
        DST_MAR  = 3'd1,
        DST_IR   = 3'd2,
        DST_RAM  = 3'd3,
        DST_X    = 3'd4,
        DST_Y    = 3'd5,
        DST_DEV  = 3'd6
    } bus_dst_e;

endpackage

// File: rtl/ucode_decode.sv
// ucode_decode
// Purely combinational decoder that turns the microinstruction in effect
// into datapath strobes, with stall and reset gating.
//
// Ports:
//   reset     in   forces all strobes off and eo_n high
//   stall     in   suppresses sink strobes, PC increment and jumps
//   uinstr    in   microinstruction in effect this cycle
//   eo_n      out  ALU output enable, active-low
//   alu_flags out  ALU function bits, passed through unconditionally
//   out_sel   out  one-hot bus source select (only when eo_n is high)
//   in_sel    out  one-hot bus sink select, bit 0 never set
//   pp        out  PC increment strobe
//   jmp       out  jump condition enables
//   rt        out  restart request for the step counter (ungated)
module ucode_decode
    import ucode_pkg::*;
#(
    parameter int SELBITS = 3
) (
    input  logic                  reset,
    input  logic                  stall,
    input  logic [UW-1:0]         uinstr,
    output logic                  eo_n,
    output logic [5:0]            alu_flags,
    output logic [2**SELBITS-1:0] out_sel,
    output logic [2**SELBITS-1:0] in_sel,
    output logic                  pp,
    output logic [3:0]            jmp,
    output logic                  rt
);

    localparam int NSEL = 2**SELBITS;

    logic        eo_raw;
    logic        strobe_en;
    logic [31:0] out_fld;
    logic [31:0] in_fld;
    logic        unused_bits;

    assign eo_raw    = uinstr[EO_BIT];
    // Sinks, PC increment and jumps must not fire while waiting on memory;
    // the bus source keeps driving so the data is valid when stall drops.
    assign strobe_en = !stall && !reset;

    // Fields widened so they compare cleanly with the select index.
    assign out_fld = 32'(uinstr[OUT_HI:OUT_LO]);
    assign in_fld  = 32'(uinstr[IN_HI:IN_LO]);

    assign eo_n      = eo_raw | reset;
    assign alu_flags = uinstr[ALU_HI:ALU_LO];
    assign pp        = eo_raw & uinstr[PP_BIT] & strobe_en;
    assign jmp       = uinstr[JMP_HI:JMP_LO] & {4{strobe_en}};
    // When eo_n is low bits 14:9 are ALU function bits, so the restart
    // bit only means "restart" in bus-move microinstructions.
    assign rt        = eo_raw & uinstr[RT_BIT];

    generate
        for (genvar gi = 0; gi < NSEL; gi++) begin : g_sel
            assign out_sel[gi] = eo_raw && !reset && (out_fld == 32'(gi));
            if (gi == 0) begin : g_in_none
                // Sink index 0 is the "no sink" encoding.
                assign in_sel[gi] = 1'b0;
            end else begin : g_in
                assign in_sel[gi] = strobe_en && (in_fld == 32'(gi));
            end
        end
    endgenerate

    // Bits 1:0 carry no function in this decoder.
    assign unused_bits = ^uinstr[1:0];

endmodule

// File: rtl/ucode_seq.sv
// ucode_seq
// Microcode sequencer: a T-state step counter that addresses an external
// combinational microcode ROM, substitutes the two hard-wired fetch
// microinstructions in T0/T1, and decodes the word in effect into
// datapath strobes in the same cycle.
//
// Ports:
//   clk       in   single clock, rising edge
//   reset     in   synchronous, active-high
//   opcode    in   current instruction opcode
//   stall     in   hold the current step (memory/device not ready)
//   rom_addr  out  microcode ROM address {opcode, tstate}
//   rom_data  in   microcode ROM word for rom_addr
//   tstate    out  current step number
//   uinstr    out  microinstruction in effect this cycle
//   eo_n      out  ALU output enable, active-low
//   alu_flags out  ALU function bits
//   out_sel   out  one-hot bus source select
//   in_sel    out  one-hot bus sink select
//   pp        out  PC increment strobe
//   jmp       out  {JC,JZ,JGT,JLT} jump enables
module ucode_seq
    import ucode_pkg::*;
#(
    parameter int            TBITS   = 3,
    parameter int            OPBITS  = 8,
    parameter int            SELBITS = 3,
    parameter logic [UW-1:0] FETCH0  = FETCH0_DEF,
    parameter logic [UW-1:0] FETCH1  = FETCH1_DEF
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [OPBITS-1:0]       opcode,
    input  logic                    stall,
    output logic [OPBITS+TBITS-1:0] rom_addr,
    input  logic [UW-1:0]           rom_data,
    output logic [TBITS-1:0]        tstate,
    output logic [UW-1:0]           uinstr,
    output logic                    eo_n,
    output logic [5:0]              alu_flags,
    output logic [2**SELBITS-1:0]   out_sel,
    output logic [2**SELBITS-1:0]   in_sel,
    output logic                    pp,
    output logic [3:0]              jmp
);

    logic [TBITS-1:0] tstate_reg;
    logic [TBITS-1:0] tstate_next;
    logic             rt;

    // The step counter is the only state in the sequencer.
    always_ff @(posedge clk) begin
        if (reset) begin
            tstate_reg <= '0;
        end else begin
            tstate_reg <= tstate_next;
        end
    end

    // Restart is ignored while stalled so a waiting step is never skipped;
    // the increment wraps naturally after the last step.
    always_comb begin
        tstate_next = tstate_reg;
        if (!stall) begin
            if (rt) begin
                tstate_next = '0;
            end else begin
                tstate_next = tstate_reg + TBITS'(1);
            end
        end
    end

    assign tstate   = tstate_reg;
    assign rom_addr = {opcode, tstate_reg};

    // Fetch steps are common to every opcode, so they bypass the ROM.
    always_comb begin
        uinstr = rom_data;
        if (tstate_reg == '0) begin
            uinstr = FETCH0;
        end else if (tstate_reg == TBITS'(1)) begin
            uinstr = FETCH1;
        end
    end

    ucode_decode #(
        .SELBITS (SELBITS)
    ) u_decode (
        .reset     (reset),
        .stall     (stall),
        .uinstr    (uinstr),
        .eo_n      (eo_n),
        .alu_flags (alu_flags),
        .out_sel   (out_sel),
        .in_sel    (in_sel),
        .pp        (pp),
        .jmp       (jmp),
        .rt        (rt)
    );

endmodule
